// File: rtl/vga_pixel_timer.sv
// vga_pixel_timer
// ---------------------------------------------------------------------------
// VGA raster timing generator. Divides the system clock by two into a pixel
// period, walks the pixel coordinate across the full line/frame (visible area
// plus porches and syncs), and re-times syncs, blanking and colour through a
// DRAW_LATENCY-deep pixel-period delay line. The delay lets an external
// drawing chain turn the coordinate into drawRGB before that pixel reaches the
// DAC.
//
// Ports
//   clk           in   system clock (two clocks per pixel period)
//   resetN        in   asynchronous active-low reset
//   drawRGB[7:0]  in   {R[2:0],G[2:0],B[1:0]} from the drawing chain
//   pixelX[10:0]  out  current horizontal coordinate, 0..H_TOTAL-1
//   pixelY[10:0]  out  current vertical coordinate, 0..V_TOTAL-1
//   pixEn         out  pixel-period strobe, high every second clk
//   startOfFrame  out  one-clk pulse at the start of each frame after the first
//   hSyncN        out  horizontal sync, active-low, delayed
//   vSyncN        out  vertical sync, active-low, delayed
//   blankN        out  high while the delayed pixel is visible
//   vgaR/G/B[3:0] out  DAC colour channels, zero while blanked
// ---------------------------------------------------------------------------
module vga_pixel_timer #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int DRAW_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  drawRGB,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        pixEn,
    output logic        startOfFrame,
    output logic        hSyncN,
    output logic        vSyncN,
    output logic        blankN,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END   = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    // Widen 3/3/2-bit colour to 4 bits per channel by replicating the MSBs,
    // so full-scale input maps to full-scale output.
    function automatic logic [11:0] expand_rgb(input logic [7:0] rgb);
        expand_rgb = {rgb[7:5], rgb[7], rgb[4:2], rgb[4], rgb[1:0], rgb[1:0]};
    endfunction

    logic                    pix_en_q, pix_en_d;
    logic [10:0]             x_q, x_d;
    logic [10:0]             y_q, y_d;
    logic                    sof_q, sof_d;
    // Delay line stages: index 0 is loaded from the live coordinate, the last
    // stage drives the outputs. Syncs are carried active-low so the cleared
    // state is already the inactive level.
    logic [DRAW_LATENCY-1:0] hsn_q, hsn_d;
    logic [DRAW_LATENCY-1:0] vsn_q, vsn_d;
    logic [DRAW_LATENCY-1:0] bln_q, bln_d;
    logic [11:0]             rgb_q, rgb_d;

    logic                    hs_raw_s;
    logic                    vs_raw_s;
    logic                    vis_raw_s;

    // Raw sync and visibility decode of the live coordinate.
    always_comb begin
        hs_raw_s  = (x_q >= H_SYNC_BEG) && (x_q < H_SYNC_END);
        vs_raw_s  = (y_q >= V_SYNC_BEG) && (y_q < V_SYNC_END);
        vis_raw_s = (x_q < H_VIS_END) && (y_q < V_VIS_END);
    end

    // Next-state logic: everything except the strobe itself moves only on
    // edges where pixEn is already high, i.e. once per pixel period.
    always_comb begin
        pix_en_d = ~pix_en_q;
        x_d      = x_q;
        y_d      = y_q;
        sof_d    = 1'b0;
        hsn_d    = hsn_q;
        vsn_d    = vsn_q;
        bln_d    = bln_q;
        rgb_d    = rgb_q;
        if (pix_en_q) begin
            if (x_q == H_LAST) begin
                x_d = 11'd0;
                if (y_q == V_LAST) begin
                    y_d   = 11'd0;
                    // Only a real wrap pulses, so the post-reset frame 0
                    // never produces a start-of-frame.
                    sof_d = 1'b1;
                end else begin
                    y_d = y_q + 11'd1;
                end
            end else begin
                x_d = x_q + 11'd1;
            end

            hsn_d[0] = ~hs_raw_s;
            vsn_d[0] = ~vs_raw_s;
            bln_d[0] = vis_raw_s;
            for (int i = 1; i < DRAW_LATENCY; i++) begin
                hsn_d[i] = hsn_q[i-1];
                vsn_d[i] = vsn_q[i-1];
                bln_d[i] = bln_q[i-1];
            end

            // Colour is captured on the same edge that loads the final
            // visibility bit, so it lines up with blankN.
            if (bln_d[DRAW_LATENCY-1]) begin
                rgb_d = expand_rgb(drawRGB);
            end else begin
                rgb_d = 12'h000;
            end
        end else begin
            pix_en_d = 1'b1;
        end
    end

    // State register with asynchronous active-low reset to the idle raster.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pix_en_q <= 1'b0;
            x_q      <= 11'd0;
            y_q      <= 11'd0;
            sof_q    <= 1'b0;
            hsn_q    <= {DRAW_LATENCY{1'b1}};
            vsn_q    <= {DRAW_LATENCY{1'b1}};
            bln_q    <= {DRAW_LATENCY{1'b0}};
            rgb_q    <= 12'h000;
        end else begin
            pix_en_q <= pix_en_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sof_q    <= sof_d;
            hsn_q    <= hsn_d;
            vsn_q    <= vsn_d;
            bln_q    <= bln_d;
            rgb_q    <= rgb_d;
        end
    end

    assign pixEn        = pix_en_q;
    assign pixelX       = x_q;
    assign pixelY       = y_q;
    assign startOfFrame = sof_q;
    assign hSyncN       = hsn_q[DRAW_LATENCY-1];
    assign vSyncN       = vsn_q[DRAW_LATENCY-1];
    assign blankN       = bln_q[DRAW_LATENCY-1];
    assign vgaR         = rgb_q[11:8];
    assign vgaG         = rgb_q[7:4];
    assign vgaB         = rgb_q[3:0];

endmodule
